// File: rtl/mem_port_arbiter.sv
// Unified I/D memory port arbiter for the RV32I pipeline.
// Data has priority; a starvation guard forces a fetch grant.
module mem_port_arbiter #(
  parameter int         AW         = 32,
  parameter int         DW         = 32,
  parameter int         STARVE_MAX = 4,
  parameter logic [2:0] WORD_TYPE  = 3'b000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_kill,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_type,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          m_valid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [2:0]    m_type,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          kill_q, kill_d;
  logic          m_valid_q, m_valid_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [2:0]    m_type_q, m_type_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;

  logic force_i;
  logic pulse;

  assign force_i = i_req & (starve_q == SMAX);
  assign pulse   = i_done_q | d_done_q;

  // Grant selection, transaction sequencing and result capture
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    kill_d    = kill_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_type_d  = m_type_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (!i_req) starve_d = '0;
        // requests held through a done pulse belong to the finished access
        if (!pulse) begin
          if (d_req && !force_i) begin
            state_d   = D_ACC;
            m_valid_d = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_type_d  = d_type;
            if (!i_req)
              starve_d = '0;
            else if (starve_q != SMAX)
              starve_d = starve_q + CW'(1);
          end else if (i_req && !i_kill) begin
            state_d   = I_ACC;
            m_valid_d = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_type_d  = WORD_TYPE;
            starve_d  = '0;
          end
        end
      end
      D_ACC: begin
        if (m_ready) begin
          d_done_d  = 1'b1;
          m_valid_d = 1'b0;
          state_d   = IDLE;
          if (!m_we_q) d_rdata_d = m_rdata;
        end
      end
      I_ACC: begin
        if (i_kill) kill_d = 1'b1;
        if (m_ready) begin
          m_valid_d = 1'b0;
          kill_d    = 1'b0;
          state_d   = IDLE;
          if (!(kill_q || i_kill)) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      kill_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_type_q  <= WORD_TYPE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      kill_q    <= kill_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_type_q  <= m_type_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_type  = m_type_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_stall = i_req & ~i_done_q;
  assign d_stall = d_req & ~d_done_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single unified instruction/data memory port between the IF-stage fetch requester and the MEM-stage load/store requester of the pipelined RV32I core.
- Sequences each access as a variable-latency transaction and produces per-stage stall signals for the hazard/pipeline-register logic.
- Data gets priority, with a starvation guard for fetch.
- Tolerates IF flush (i_kill) while a fetch is in flight.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is waiting before fetch is forced to win.
- WORD_TYPE, 3'b000, DMType encoding driven on m_type for instruction fetches (word access).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_done or i_kill.
- i_addr  in  AW  fetch address (PC).
- i_kill  in  1  flush of the fetch in flight (branch/jump taken).
- i_rdata  out  DW  fetched instruction, valid when i_done=1.
- i_done  out  1  one-cycle fetch completion pulse.
- i_stall  out  1  stall for PC/IF-ID registers.
- d_req  in  1  load/store request; held with d_* until d_done.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address (ALU result).
- d_wdata  in  DW  store data.
- d_type  in  3  DMType of the access.
- d_rdata  out  DW  load data, valid when d_done=1.
- d_done  out  1  one-cycle data completion pulse.
- d_stall  out  1  stall for pipeline stages up to and including MEM.
- m_valid  out  1  memory transaction valid.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_type  out  3  memory access type.
- m_rdata  in  DW  memory read data, valid with m_ready.
- m_ready  in  1  memory completion; may be asserted in the first m_valid cycle.

Behaviour:
- Reset (async, rstn=0): state IDLE; m_valid, m_we, i_done, d_done = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; m_type = WORD_TYPE; starve counter = 0; kill flag = 0. Any memory transaction in flight is abandoned; memory must tolerate this.
- States: IDLE, D_ACC, I_ACC.
- IDLE:
  - Grant data if d_req, unless fetch is forced (i_req & starve==STARVE_MAX).
  - Otherwise grant fetch if i_req & ~i_kill.
  - The granted request's signals are registered onto m_*. m_valid=1 from the next cycle. Fetch uses m_we=0 and m_type=WORD_TYPE.
- D_ACC / I_ACC: m_* held constant while m_valid=1. On m_ready:
  - Capture m_rdata into d_rdata or i_rdata.
  - Pulse d_done or i_done for exactly the next cycle.
  - Drop m_valid and return to IDLE.
  - Minimum transaction length is 2 cycles (grant to done pulse); there is at least one IDLE cycle between transactions.
- Output persistence: d_rdata and i_rdata hold until the next capture. On a store, d_rdata is not updated.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each data grant while i_req=1.
  - Clears on a fetch grant or when i_req=0 in IDLE.
- i_kill:
  - In IDLE, suppresses a fetch grant that cycle.
  - In I_ACC, sets the kill flag. The transaction still completes on the port (no abort), but i_done is suppressed and i_rdata is not updated. The flag clears on exit.
  - i_kill with d_req present does not affect the data grant.
- Stalls (combinational from state/registers):
  - d_stall = d_req & ~d_done.
  - i_stall = i_req & ~i_done.
  - The requester advances in the cycle where done=1. It may present a new request in that same cycle; the request is seen in IDLE on the following cycle.
- Simultaneous d_req and i_req in IDLE with starve<STARVE_MAX: data wins; i_stall stays 1.
- m_ready while m_valid=0 is ignored.
- Arithmetic: counter width $clog2(STARVE_MAX+1); no address arithmetic.

Test Plan:
- Reset then single fetch: i_req=1, i_addr=0x0000_0004, m_ready asserted 1 cycle after m_valid, m_rdata=0x0010_0093 -> m_addr=0x4, m_we=0, m_type=3'b000; i_done pulses once on cycle 3 with i_rdata=0x0010_0093; i_stall=1 until that cycle.
- Store then load, 3-cycle memory latency: store d_addr=0x100, d_wdata=0xDEAD_BEEF, d_type=word, then load from 0x100 -> m_we=1 held for 3 cycles; second transaction returns d_rdata=0xDEAD_BEEF; d_stall covers both accesses.
- Contention: i_req and d_req both asserted -> data granted first; fetch granted only after d_done plus one IDLE cycle.
- Starvation: i_req held and d_req re-asserted back-to-back 6 times, STARVE_MAX=4 -> fetch is granted after the 4th data completion, then data resumes.
- Kill in flight: fetch to 0x20 in I_ACC, i_kill=1 for 1 cycle, memory returns 0xFFFF_FFFF -> no i_done; i_rdata keeps its old value; next fetch to 0x40 completes normally.
- Async reset mid-D_ACC: rstn low for 1 cycle during a store -> m_valid drops immediately without waiting for clk; outputs hold reset values; after release, a pending i_req is granted normally.
